// File: rtl/xor_parity_pkg.sv
// Purpose: shared encodings for the XOR/XNOR parity receive and transmit path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xor_parity_pkg;

    // Receiver frame state; encodings are fixed so waveforms and other
    // blocks on the parity path can decode them directly.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Parity mode selection: the value is the required XOR of data + parity bit.
    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// Purpose: one-bit running XOR accumulator, shared by the parity receiver and transmitter.
// Latency: acc reflects clr/en/d one cycle after the sampling edge.
// Backpressure: none; en gates updates, acc holds when en=0.
//
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high reset, clears acc
//   clr - synchronous clear (takes priority over en)
//   en  - fold d into the accumulator this cycle
//   d   - data bit to fold in
//   acc - running XOR of all bits folded in since the last clear
module parity_accum (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic acc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= 1'b0;
        end else if (clr) begin
            acc <= 1'b0;
        end else if (en) begin
            acc <= acc ^ d;
        end
    end

endmodule

// File: rtl/xor_parity_rx.sv
// Purpose: serial start/data/parity/stop receiver with XOR parity and stop-bit checking.
// Latency: data_valid pulses the cycle after the edge that samples the stop-bit strobe.
// Backpressure: none; the bit source paces the frame via bit_valid, gaps simply hold state.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset, discards any partial frame
//   bit_valid  - qualifies bit_in for this cycle only
//   bit_in     - serial line value, idles high
//   data_out   - last reported word, first received bit at bit 0
//   data_valid - one-cycle pulse per completed frame
//   parity_err - parity mismatch for the reported frame
//   frame_err  - stop bit was 0 for the reported frame
//   busy       - a frame is in progress (start accepted, not yet reported)
module xor_parity_rx
    import xor_parity_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter bit          ODD_PARITY = PAR_EVEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    // Counter only needs to reach DATA_W, so it never wraps inside a frame.
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_nxt;
    logic              perr_q;
    logic              acc;
    logic              acc_clr;
    logic              acc_en;
    logic              last_data;

    assign last_data = (bit_cnt == CNT_W'(DATA_W - 1));
    assign busy      = (state != ST_IDLE);

    // Right shift: new bits enter at the MSB, so after DATA_W strobes the
    // first bit on the line sits at bit 0. A 1-bit word is just the bit.
    generate
        if (DATA_W == 1) begin : g_shift_one
            assign shift_nxt = bit_in;
        end else begin : g_shift_wide
            assign shift_nxt = {bit_in, shift_q[DATA_W-1:1]};
        end
    endgenerate

    parity_accum u_accum (
        .clk (clk),
        .rst (rst),
        .clr (acc_clr),
        .en  (acc_en),
        .d   (bit_in),
        .acc (acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                // A high strobe in idle is line idle, not a start bit.
                if (bit_valid && !bit_in) begin
                    state_nxt = ST_DATA;
                    acc_clr   = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_valid) begin
                    acc_en = 1'b1;
                    if (last_data) begin
                        state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_valid) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Always back to idle, even on a 0 stop bit: a bad stop bit is
                // never taken as the next start bit.
                if (bit_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Bit counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (bit_valid) begin
            if (state == ST_IDLE) begin
                bit_cnt <= '0;
            end else if (state == ST_DATA) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
                shift_q <= shift_nxt;
            end
        end
    end

    // Parity verdict is captured on the parity strobe and only published
    // with the stop bit, so outputs change once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (bit_valid && state == ST_PARITY) begin
            perr_q <= acc ^ bit_in ^ ODD_PARITY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (bit_valid && state == ST_STOP) begin
                data_out   <= shift_q;
                parity_err <= perr_q;
                frame_err  <= ~bit_in;
                data_valid <= 1'b1;
            end
        end
    end

endmodule
